// File: rtl/mem_responder_if.sv
// Purpose : CPU <-> memory-responder handshake bundle (request lines, address/data, response).
// Latency : n/a (wires only).
// Backpressure: request lines are level-held by the CPU until ACK; the responder waits for release.
// Ports   : MREQ_N/MIRQ_N/R_W_N/ADDR/WDATA driven by the CPU side (master);
//           RDATA/ISR/ACK/BUSY (and ERR when MEM_RANGE_CHK_EN is defined) driven by the responder (slave).
interface mem_responder_if #(
  parameter int AW = 8
);
  logic          MREQ_N;
  logic          MIRQ_N;
  logic          R_W_N;
  logic [AW-1:0] ADDR;
  logic [15:0]   WDATA;
  logic [15:0]   RDATA;
  logic [15:0]   ISR;
  logic          ACK;
  logic          BUSY;
`ifdef MEM_RANGE_CHK_EN
  logic          ERR;
`endif

  modport master (
    output MREQ_N, MIRQ_N, R_W_N, ADDR, WDATA,
`ifdef MEM_RANGE_CHK_EN
    input  ERR,
`endif
    input  RDATA, ISR, ACK, BUSY
  );

  modport slave (
    input  MREQ_N, MIRQ_N, R_W_N, ADDR, WDATA,
`ifdef MEM_RANGE_CHK_EN
    output ERR,
`endif
    output RDATA, ISR, ACK, BUSY
  );
endinterface

// File: rtl/mem_responder.sv
// Purpose : memory-side responder; serves data reads/writes and instruction fetches from an
//           internal word-addressed RAM, holding the last fetched instruction in ISR.
// Latency : ACK is a one-cycle pulse registered WAIT_CYCLES+1 edges after the request sample edge.
// Backpressure: after ACK the FSM parks in HOLD until both request lines are released, so a
//           request held low produces exactly one ACK; turnaround is WAIT_CYCLES+3 cycles minimum.
// Ports   : clk, reset (async, active-high); bus = mem_responder_if.slave
//           (MREQ_N, MIRQ_N, R_W_N, ADDR, WDATA in; RDATA, ISR, ACK, BUSY out).
// Optional: define MEM_RANGE_CHK_EN to add bus.ERR; out-of-range accesses then suppress writes
//           and return 16'hFFFF instead of folding the address.
module mem_responder #(
  parameter int AW          = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  // Index width used for folding: ADDR mod 2^clog2(DEPTH).  The array covers the whole
  // power-of-two window so a folded index can never fall outside it.
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORDS = 1 << IW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_wdata;
  logic          r_wr;
  logic          r_fetch;
  logic [15:0]   r_rdata;
  logic [15:0]   r_isr;
  logic          r_ack;
  logic          r_busy;
  logic [15:0]   r_mem [WORDS];

  logic          w_req;
  logic          w_fetch_in;
  logic          w_wr_in;
  logic          w_release;
  logic [IW-1:0] w_idx;
  logic          w_oob;
  logic [15:0]   w_rd_word;
  logic          w_mem_we;

  assign w_req      = !bus.MREQ_N || !bus.MIRQ_N;
  // MIRQ_N low makes the access a fetch even if MREQ_N is also low; R_W_N is then ignored.
  assign w_fetch_in = !bus.MIRQ_N;
  assign w_wr_in    = bus.MIRQ_N && !bus.MREQ_N && !bus.R_W_N;
  assign w_release  = bus.MREQ_N && bus.MIRQ_N;
  assign w_idx      = r_addr[IW-1:0];

`ifdef MEM_RANGE_CHK_EN
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  logic r_err;

  assign w_oob = ({1'b0, r_addr} >= DEPTH_W);

  // ERR shares ACK's timing: set on the RESP edge, cleared on every other edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_RESP) && w_oob;
    end
  end

  assign bus.ERR = r_err;
`else
  assign w_oob = 1'b0;
`endif

  assign w_rd_word = w_oob ? 16'hFFFF : r_mem[w_idx];
  // Writes commit only on the RESP edge, so a reset during WAIT leaves the RAM untouched.
  assign w_mem_we  = (r_state == S_RESP) && r_wr && !w_oob;

  // RAM storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 16'h0000;
      r_wr    <= 1'b0;
      r_fetch <= 1'b0;
      r_rdata <= 16'h0000;
      r_isr   <= 16'h0000;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          if (w_req) begin
            r_addr  <= bus.ADDR;
            r_wdata <= bus.WDATA;
            r_fetch <= w_fetch_in;
            r_wr    <= w_wr_in;
            r_busy  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
              r_cnt   <= 4'd0;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end

        S_WAIT: begin
          // Bus inputs are ignored here; only the latched request is used.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end

        S_RESP: begin
          r_ack   <= 1'b1;
          r_state <= S_HOLD;
          if (!r_wr) begin
            r_rdata <= w_rd_word;
            if (r_fetch) begin
              r_isr <= w_rd_word;
            end
          end
        end

        S_HOLD: begin
          r_ack <= 1'b0;
          if (w_release) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RDATA = r_rdata;
  assign bus.ISR   = r_isr;
  assign bus.ACK   = r_ack;
  assign bus.BUSY  = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Purpose : directed self-checking bench for mem_responder (AW=8, DEPTH=200, WAIT_CYCLES=2).
// Latency : expects ACK visible after the 4th rising edge counted from the request sample edge.
// Backpressure: requests are held low until ACK (plus optional extra cycles), then released.
module tb_mem_responder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic r_err_seen;

  mem_responder_if #(.AW(8)) bus ();

  mem_responder #(
    .AW          (8),
    .DEPTH       (200),
    .WAIT_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete handshake: drive at a falling edge, wait (bounded) for ACK, hold the request
  // for 'hold' more cycles while counting ACKs, then release and expect BUSY to drop.
  task automatic access(input string tag, input logic mreq_n, input logic mirq_n,
                        input logic rwn, input logic [7:0] addr, input logic [15:0] wd,
                        input int hold, output logic err);
    int n;
    int acks;
    bit seen;
    @(negedge clk);
    bus.MREQ_N = mreq_n;
    bus.MIRQ_N = mirq_n;
    bus.R_W_N  = rwn;
    bus.ADDR   = addr;
    bus.WDATA  = wd;
    n    = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.ACK) seen = 1;
    end
    chk({tag, "_lat"}, seen ? n : 99, 4);
`ifdef MEM_RANGE_CHK_EN
    err = bus.ERR;
`else
    err = 1'b0;
`endif
    acks = seen ? 1 : 0;
    repeat (hold + 1) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ACK) acks++;
    end
    chk({tag, "_busy_hold"}, bus.BUSY, 1);
    chk({tag, "_acks"}, acks, 1);
    bus.MREQ_N = 1'b1;
    bus.MIRQ_N = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy_idle"}, bus.BUSY, 0);
  endtask

  initial begin
    int acks;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    bus.MREQ_N = 1'b1;
    bus.MIRQ_N = 1'b1;
    bus.R_W_N  = 1'b1;
    bus.ADDR   = 8'h00;
    bus.WDATA  = 16'h0000;
    repeat (3) @(negedge clk);

    chk("rst_rdata", bus.RDATA, 16'h0000);
    chk("rst_isr",   bus.ISR,   16'h0000);
    chk("rst_ack",   bus.ACK,   0);
    chk("rst_busy",  bus.BUSY,  0);
`ifdef MEM_RANGE_CHK_EN
    chk("rst_err",   bus.ERR,   0);
`endif
    reset = 1'b0;

    // Preload 0x10 with a write; RDATA and ISR must not move on a write.
    access("wr10", 1'b0, 1'b1, 1'b0, 8'h10, 16'h1234, 0, r_err_seen);
    chk("wr10_rdata", bus.RDATA, 16'h0000);
    chk("wr10_isr",   bus.ISR,   16'h0000);

    // Fetch via MIRQ_N alone.
    access("fetch10", 1'b1, 1'b0, 1'b1, 8'h10, 16'h0000, 0, r_err_seen);
    chk("fetch10_rdata", bus.RDATA, 16'h1234);
    chk("fetch10_isr",   bus.ISR,   16'h1234);
`ifdef MEM_RANGE_CHK_EN
    chk("fetch10_err", r_err_seen, 0);
`endif

    // Write then read back, read request held 10 cycles beyond ACK.
    access("wr20", 1'b0, 1'b1, 1'b0, 8'h20, 16'hBEEF, 0, r_err_seen);
    access("rd20", 1'b0, 1'b1, 1'b1, 8'h20, 16'h0000, 10, r_err_seen);
    chk("rd20_rdata", bus.RDATA, 16'hBEEF);
    chk("rd20_isr",   bus.ISR,   16'h1234);

    // Both request lines low with R_W_N=0 is a fetch: no write.
    access("wr30", 1'b0, 1'b1, 1'b0, 8'h30, 16'h00AA, 0, r_err_seen);
    access("both30", 1'b0, 1'b0, 1'b0, 8'h30, 16'h1111, 0, r_err_seen);
    chk("both30_rdata", bus.RDATA, 16'h00AA);
    chk("both30_isr",   bus.ISR,   16'h00AA);
    access("rd30", 1'b0, 1'b1, 1'b1, 8'h30, 16'h0000, 0, r_err_seen);
    chk("rd30_nowrite", bus.RDATA, 16'h00AA);

    // Reset during WAIT of a write aborts it: no ACK, RAM keeps the old word.
    access("wr40", 1'b0, 1'b1, 1'b0, 8'h40, 16'h5555, 0, r_err_seen);
    @(negedge clk);
    bus.MREQ_N = 1'b0;
    bus.R_W_N  = 1'b0;
    bus.ADDR   = 8'h40;
    bus.WDATA  = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_wait", bus.BUSY, 1);
    reset = 1'b1;
    acks  = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ACK) acks++;
    end
    chk("abort_acks", acks, 0);
    chk("abort_busy", bus.BUSY, 0);
    chk("abort_rdata", bus.RDATA, 16'h0000);
    bus.MREQ_N = 1'b1;
    bus.R_W_N  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    access("rd40", 1'b0, 1'b1, 1'b1, 8'h40, 16'h0000, 0, r_err_seen);
    chk("rd40_rdata", bus.RDATA, 16'h5555);
    chk("rd40_isr",   bus.ISR,   16'h0000);

    // Address 0xF0 is at or above DEPTH=200.
    access("wrF0", 1'b0, 1'b1, 1'b0, 8'hF0, 16'hCAFE, 0, r_err_seen);
    access("rdF0", 1'b0, 1'b1, 1'b1, 8'hF0, 16'h0000, 0, r_err_seen);
`ifdef MEM_RANGE_CHK_EN
    chk("rdF0_err",   r_err_seen, 1);
    chk("rdF0_rdata", bus.RDATA, 16'hFFFF);
    access("fetchF0", 1'b1, 1'b0, 1'b1, 8'hF0, 16'h0000, 0, r_err_seen);
    chk("fetchF0_err", r_err_seen, 1);
    chk("fetchF0_isr", bus.ISR, 16'hFFFF);
    chk("err_clear", bus.ERR, 0);
`else
    chk("rdF0_rdata", bus.RDATA, 16'hCAFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
